// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 4;

  // Ceiling log2: the number of bits needed to hold values 0..value-1.
  function automatic int unsigned fifo_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_gen: synchronous write, asynchronous read address.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Single-clock FIFO: binary wrap-bit pointers, level/threshold flags, sticky error
// flags and a selectable registered or first-word-fall-through read port.
module sync_fifo_gen
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned AF_LEVEL = (2**ADDR_W) - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int unsigned     Depth   = 2**ADDR_W;
  localparam int unsigned     LevelW  = fifo_clog2(Depth + 1);
  localparam logic [ADDR_W:0] PtrOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AfLevel = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AeLevel = AE_LEVEL[ADDR_W:0];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_accept, rd_accept;
  logic [LevelW-1:0] level_w;
  logic [DATA_W-1:0] mem_rdata;

  // Flags come from registered pointers only, so no input reaches an output combinationally.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level_w = wr_ptr_q - rd_ptr_q;
  assign level   = level_w;

  assign almost_full  = (level_w >= AfLevel);
  assign almost_empty = (level_w <= AeLevel);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    // A new error in the same cycle as err_clr must not be lost.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr_q[ADDR_W-1:0]),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q[ADDR_W-1:0]),
    .rd_data(mem_rdata)
  );

  if (FWFT) begin : g_fwft
    assign rd_data  = mem_rdata;
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) begin
          rd_data_q <= mem_rdata;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Bench for sync_fifo_gen: registered-read instance checked by a read scoreboard,
// FWFT instance checked with directed expectations.
module tb_sync_fifo_gen;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, err_clr;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  level;

  logic        f_rst, f_wr_en, f_rd_en, f_err_clr;
  logic [31:0] f_wr_data, f_rd_data;
  logic        f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic        f_overflow, f_underflow;
  logic [4:0]  f_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_fifo_gen #(.FWFT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  sync_fifo_gen #(.FWFT(1'b1)) u_dut_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .level(f_level),
    .overflow(f_overflow), .underflow(f_underflow), .err_clr(f_err_clr)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Drive one cycle of stimulus on the registered instance; expected reads go to the scoreboard.
  task automatic tick(input logic w, input logic [31:0] d, input logic r, input logic c);
    bit   wa, ra;
    exp_t e;
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    err_clr = c;
    wa = w && (model_q.size() < 16);
    ra = r && (model_q.size() > 0);
    if (ra) begin
      e.data = model_q.pop_front();
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    if (wa) model_q.push_back(d);
  endtask

  task automatic ftick(input logic w, input logic [31:0] d, input logic r, input logic rs);
    @(negedge clk);
    f_wr_en   = w;
    f_wr_data = d;
    f_rd_en   = r;
    f_rst     = rs;
  endtask

  // Monitor: every rd_valid must match the oldest expected read, on its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", {31'd0, rd_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_latency", cyc, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("rd_valid_missing", {31'd0, rd_valid}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_wr_data = '0;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    f_rst = 1'b0;

    // Reset state
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_almost_empty", {31'd0, almost_empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_almost_full", {31'd0, almost_full}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);

    // Fill: outputs at each tick reflect k completed writes
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) tick(1'b1, k, 1'b0, 1'b0);
      else        tick(1'b0, 32'd0, 1'b0, 1'b0);
      chk("fill_level", {27'd0, level}, k);
      chk("fill_almost_full", {31'd0, almost_full}, {31'd0, k >= 14});
      chk("fill_full", {31'd0, full}, {31'd0, k == 16});
      chk("fill_almost_empty", {31'd0, almost_empty}, {31'd0, k <= 2});
    end

    // Dropped write while full
    tick(1'b1, 32'hEE, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_level", {27'd0, level}, 32'd16);
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("ovf_clear", {31'd0, overflow}, 32'd0);

    // Drain 16, then one read while empty
    for (int i = 0; i < 16; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("udf_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("udf_set", {31'd0, underflow}, 32'd1);
    chk("udf_empty", {31'd0, empty}, 32'd1);
    tick(1'b0, 32'd0, 1'b0, 1'b1);

    // Wrap: steady level 3 with 40 write/read pairs
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h100 + i, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 32'h200 + i, 1'b1, 1'b0);
      if (i == 1 || i == 20) chk("wrap_level_mid", {27'd0, level}, 32'd3);
    end
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap_level", {27'd0, level}, 32'd3);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Collision at empty: write wins, read flagged
    tick(1'b1, 32'h55, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("coll_empty_level", {27'd0, level}, 32'd1);
    chk("coll_empty_udf", {31'd0, underflow}, 32'd1);
    tick(1'b0, 32'd0, 1'b0, 1'b1);

    // Collision at full: read wins, write flagged
    for (int i = 0; i < 15; i++) tick(1'b1, 32'h60 + i, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("coll_full_pre", {31'd0, full}, 32'd1);
    tick(1'b1, 32'h77, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("coll_full_level", {27'd0, level}, 32'd15);
    chk("coll_full_ovf", {31'd0, overflow}, 32'd1);
    chk("coll_full_full", {31'd0, full}, 32'd0);
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("final_empty", {31'd0, empty}, 32'd1);
    chk("final_underflow", {31'd0, underflow}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    // FWFT instance
    chk("fwft_rst_empty", {31'd0, f_empty}, 32'd1);
    chk("fwft_rst_valid", {31'd0, f_rd_valid}, 32'd0);
    ftick(1'b1, 32'hA5, 1'b0, 1'b0);
    ftick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("fwft_valid", {31'd0, f_rd_valid}, 32'd1);
    chk("fwft_data", f_rd_data, 32'hA5);
    ftick(1'b0, 32'd0, 1'b1, 1'b0);
    ftick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("fwft_pop_empty", {31'd0, f_empty}, 32'd1);
    chk("fwft_pop_valid", {31'd0, f_rd_valid}, 32'd0);
    for (int i = 0; i < 8; i++) ftick(1'b1, 32'h30 + i, 1'b0, 1'b0);
    ftick(1'b0, 32'd0, 1'b1, 1'b0);
    ftick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("fwft_level7", {27'd0, f_level}, 32'd7);
    chk("fwft_head", f_rd_data, 32'h31);
    ftick(1'b0, 32'd0, 1'b0, 1'b1);
    ftick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("fwft_rst_mid_empty", {31'd0, f_empty}, 32'd1);
    chk("fwft_rst_mid_level", {27'd0, f_level}, 32'd0);
    chk("fwft_rst_mid_valid", {31'd0, f_rd_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
